// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 port arbiter: FSM states, owner/op
// encodings and the burst-length clamp used when a request is captured.
package l2_arb_pkg;

  localparam int L2_BUF_DEPTH = 16;
  localparam int L2_IDX_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_MEM_RD,
    ST_STREAM,
    ST_COLLECT,
    ST_MEM_WR
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // A zero-length burst still moves one word; anything longer than the buffer is cut to fit.
  function automatic int clampBurst(input logic [4:0] size, input int maxLen);
    int len;
    len = int'(size);
    if (len == 0) begin
      len = 1;
    end else if (len > maxLen) begin
      len = maxLen;
    end
    return len;
  endfunction

endpackage

// File: rtl/l2_arb_linebuf.sv
// Line buffer: DEPTH x 32 register file with one synchronous write port
// and one combinational read port.
module l2_arb_linebuf
  import l2_arb_pkg::*;
#(
  parameter int DEPTH = L2_BUF_DEPTH,
  parameter int IDX_W = L2_IDX_W
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2/memory port between the ICache refill port and the DCache,
// staging every burst through a line buffer so caches never stall mid-stream.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int BUF_DEPTH = L2_BUF_DEPTH,
  parameter int IDX_W     = L2_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rreq,
  input  logic [31:0] i_addr,
  input  logic [4:0]  i_burst_size,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        d_rreq,
  input  logic        d_wreq,
  input  logic [31:0] d_addr,
  input  logic [4:0]  d_burst_size,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        invalid_req,
  output logic [26:0] invalid_line
);

  localparam int LEN_W = IDX_W + 1;
  typedef logic [LEN_W-1:0] len_t;

  state_t      r_state, w_nextState;
  logic        r_pendI, r_pendD;
  logic [31:0] r_iAddr, r_dAddr, r_base;
  len_t        r_iLen, r_dLen, r_len, r_count;
  op_t         r_dOp, r_op;
  owner_t      r_owner, r_rrLast;
  logic [31:0] r_iHold, r_dHold;
  logic        r_invReq;
  logic [26:0] r_invLine;

  logic        w_grantI, w_grantD, w_lastWord, w_iActive, w_dActive;
  logic        w_bufWe, w_memPhase, w_streamI, w_streamD;
  logic [31:0] w_bufWdata, w_bufRdata;

  assign w_lastWord = (r_count == (r_len - len_t'(1)));
  assign w_iActive  = r_pendI | ((r_owner == OWN_I) && (r_state != ST_IDLE));
  assign w_dActive  = r_pendD | ((r_owner == OWN_D) && (r_state != ST_IDLE));
  assign w_memPhase = (r_state == ST_GRANT) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_streamI  = (r_state == ST_STREAM) && (r_owner == OWN_I);
  assign w_streamD  = (r_state == ST_STREAM) && (r_owner == OWN_D);

  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_bufWe     = 1'b0;
    w_bufWdata  = mem_rdata;
    case (r_state)
      ST_IDLE: begin
        // Round-robin only matters on a tie; rr_last names the last winner.
        if (r_pendI && (!r_pendD || (r_rrLast == OWN_D))) begin
          w_grantI    = 1'b1;
          w_nextState = ST_GRANT;
        end else if (r_pendD) begin
          w_grantD    = 1'b1;
          w_nextState = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_nextState = (r_op == OP_WR) ? ST_COLLECT : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          w_bufWe = 1'b1;
          if (w_lastWord) w_nextState = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_lastWord) w_nextState = ST_IDLE;
      end
      ST_COLLECT: begin
        w_bufWe    = 1'b1;
        w_bufWdata = d_wdata;
        if (w_lastWord) w_nextState = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        if (mem_ack && w_lastWord) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pendI   <= 1'b0;
      r_pendD   <= 1'b0;
      r_iAddr   <= '0;
      r_dAddr   <= '0;
      r_base    <= '0;
      r_iLen    <= len_t'(1);
      r_dLen    <= len_t'(1);
      r_len     <= len_t'(1);
      r_count   <= '0;
      r_dOp     <= OP_RD;
      r_op      <= OP_RD;
      r_owner   <= OWN_I;
      r_rrLast  <= OWN_D;
      r_iHold   <= '0;
      r_dHold   <= '0;
      r_invReq  <= 1'b0;
      r_invLine <= '0;
    end else begin
      r_state  <= w_nextState;
      r_invReq <= 1'b0;

      if (w_grantI) begin
        r_pendI  <= 1'b0;
        r_owner  <= OWN_I;
        r_rrLast <= OWN_I;
        r_base   <= r_iAddr;
        r_len    <= r_iLen;
        r_op     <= OP_RD;
      end else if (i_rreq && !w_iActive) begin
        r_pendI <= 1'b1;
        r_iAddr <= i_addr;
        r_iLen  <= len_t'(clampBurst(i_burst_size, BUF_DEPTH));
      end

      // A simultaneous read and write pulse from the DCache is taken as a write.
      if (w_grantD) begin
        r_pendD  <= 1'b0;
        r_owner  <= OWN_D;
        r_rrLast <= OWN_D;
        r_base   <= r_dAddr;
        r_len    <= r_dLen;
        r_op     <= r_dOp;
      end else if ((d_rreq || d_wreq) && !w_dActive) begin
        r_pendD <= 1'b1;
        r_dAddr <= d_addr;
        r_dLen  <= len_t'(clampBurst(d_burst_size, BUF_DEPTH));
        r_dOp   <= d_wreq ? OP_WR : OP_RD;
      end

      case (r_state)
        ST_GRANT: r_count <= '0;
        ST_MEM_RD: begin
          if (mem_ack) r_count <= w_lastWord ? len_t'(0) : r_count + len_t'(1);
        end
        ST_STREAM: begin
          r_count <= w_lastWord ? len_t'(0) : r_count + len_t'(1);
          if (r_owner == OWN_I) r_iHold <= w_bufRdata;
          else                  r_dHold <= w_bufRdata;
        end
        ST_COLLECT: r_count <= w_lastWord ? len_t'(0) : r_count + len_t'(1);
        ST_MEM_WR: begin
          if (mem_ack) begin
            if (w_lastWord) begin
              r_count   <= '0;
              r_invReq  <= 1'b1;
              r_invLine <= r_base[31:5];
            end else begin
              r_count <= r_count + len_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  l2_arb_linebuf #(
    .DEPTH (BUF_DEPTH),
    .IDX_W (IDX_W)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_bufWe),
    .i_waddr (r_count[IDX_W-1:0]),
    .i_wdata (w_bufWdata),
    .i_raddr (r_count[IDX_W-1:0]),
    .o_rdata (w_bufRdata)
  );

  assign mem_req      = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign mem_we       = (r_state == ST_MEM_WR);
  assign mem_addr     = r_base + (32'(r_count) << 2);
  assign mem_wdata    = w_bufRdata;
  assign i_busy       = r_pendI | ((r_owner == OWN_I) && w_memPhase);
  assign d_busy       = r_pendD | ((r_owner == OWN_D) && w_memPhase);
  assign i_rdata      = w_streamI ? w_bufRdata : r_iHold;
  assign d_rdata      = w_streamD ? w_bufRdata : r_dHold;
  assign invalid_req  = r_invReq;
  assign invalid_line = r_invLine;

endmodule
